// File: rtl/split_target_mem_ctrl_pkg.sv
// Shared types and constants for the split-capable memory target.
package split_target_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ADDR  = 4'd1,
    S_WDATA = 4'd2,
    S_WACK  = 4'd3,
    S_SPLIT = 4'd4,
    S_WAIT  = 4'd5,
    S_REQ   = 4'd6,
    S_SEND  = 4'd7,
    S_DRAIN = 4'd8
  } tgt_state_t;

  // One serializer load cycle plus eight shift cycles.
  localparam int TX_DRAIN_CYCLES = 9;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

endpackage

// File: rtl/split_target_mem_ctrl_ram.sv
// Local byte store: synchronous write, asynchronous (combinational) read.
module target_byte_ram
  import split_target_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/split_target_mem_ctrl.sv
// Split-capable memory target: collects address/data bytes from the port,
// writes or reads the local byte RAM, and answers with ack or a split read.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | ready; waiting for target_sel, latches bus_mode
//  S_ADDR  | shifting in address bytes, LSB first
//  S_WDATA | waiting for the write data byte
//  S_WACK  | one-cycle write completion ack
//  S_SPLIT | one-cycle split ack, bus released
//  S_WAIT  | split latency countdown
//  S_REQ   | split_req held until split_grant
//  S_SEND  | read byte presented with a one-cycle valid strobe
//  S_DRAIN | wait for the port serializer, then ack
module split_target_mem_ctrl
  import split_target_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned ADDR_BYTES    = 2,
  parameter bit          SPLIT_EN      = 1'b1,
  parameter int unsigned SPLIT_LATENCY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       target_sel,
  input  logic       bus_mode,
  input  logic [7:0] target_data_in,
  input  logic       target_data_in_valid,
  input  logic       split_grant,
  output logic [7:0] target_data_out,
  output logic       target_data_out_valid,
  output logic       target_rw,
  output logic       target_ready,
  output logic       target_ack,
  output logic       target_split_ack,
  output logic       split_req
);

  localparam int unsigned LAT_W  = $clog2(SPLIT_LATENCY + 1);
  localparam int unsigned BIDX_W = $clog2(ADDR_BYTES + 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(ADDR_BYTES - 1);

  tgt_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BIDX_W-1:0]     byte_idx;
  logic [LAT_W-1:0]      lat_cnt;
  logic [3:0]            drain_cnt;
  logic [7:0]            data_q;
  logic [7:0]            ram_rdata;
  logic                  ram_we;
  logic                  byte_in;
  logic                  last_addr_byte;

  assign byte_in        = target_sel && target_data_in_valid;
  assign last_addr_byte = byte_in && (byte_idx == LAST_BYTE);
  assign ram_we         = (state_q == S_WDATA) && byte_in;

  target_byte_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr_q),
    .wdata(target_data_in),
    .rdata(ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; dropping target_sel aborts only while still receiving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (target_sel) state_d = S_ADDR;
      S_ADDR: begin
        if (!target_sel) begin
          state_d = S_IDLE;
        end else if (last_addr_byte) begin
          if (target_rw == MODE_WRITE) state_d = S_WDATA;
          else if (SPLIT_EN)           state_d = S_SPLIT;
          else                         state_d = S_SEND;
        end
      end
      S_WDATA: begin
        if (!target_sel)  state_d = S_IDLE;
        else if (byte_in) state_d = S_WACK;
      end
      S_WACK:  state_d = S_IDLE;
      S_SPLIT,
      S_WAIT:  state_d = (lat_cnt == LAT_W'(1)) ? S_REQ : S_WAIT;
      S_REQ:   if (split_grant) state_d = S_SEND;
      S_SEND:  state_d = S_DRAIN;
      S_DRAIN: if (drain_cnt == 4'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state so reset clears strobes and requests at once.
  always_comb begin
    target_ready          = (state_q == S_IDLE);
    target_split_ack      = (state_q == S_SPLIT);
    split_req             = (state_q == S_REQ);
    target_data_out_valid = (state_q == S_SEND);
    target_ack            = (state_q == S_WACK) ||
                            ((state_q == S_DRAIN) && (drain_cnt == 4'd1));
    target_data_out       = (state_q == S_SEND) ? ram_rdata : data_q;
  end

  // Transaction datapath: mode latch, address assembly, latency/drain timers, read hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_rw <= 1'b0;
      addr_q    <= '0;
      byte_idx  <= '0;
      lat_cnt   <= '0;
      drain_cnt <= '0;
      data_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (target_sel) begin
            target_rw <= bus_mode;
            addr_q    <= '0;
            byte_idx  <= '0;
          end
        end
        S_ADDR: begin
          if (byte_in) begin
            // Address bits beyond ADDR_WIDTH are simply not stored.
            for (int b = 0; b < ADDR_WIDTH; b++) begin
              if ((b / 8) == int'(byte_idx)) addr_q[b] <= target_data_in[3'(b % 8)];
            end
            byte_idx <= byte_idx + BIDX_W'(1);
          end
        end
        S_SPLIT,
        S_WAIT:  lat_cnt <= lat_cnt - LAT_W'(1);
        S_SEND: begin
          data_q    <= ram_rdata;
          drain_cnt <= 4'(TX_DRAIN_CYCLES);
        end
        S_DRAIN: drain_cnt <= drain_cnt - 4'd1;
        default: ;
      endcase
      // Loaded on entry so the count reads SPLIT_LATENCY during the split ack cycle.
      if (state_d == S_SPLIT && state_q != S_SPLIT) lat_cnt <= LAT_W'(SPLIT_LATENCY);
    end
  end

endmodule

// File: tb/tb_split_target_mem_ctrl.sv
// Self-checking bench: one split-enabled target (index 0) and one
// immediate-read target (index 1), directed steps followed by random traffic.
module tb_split_target_mem_ctrl;

  localparam int LAT   = 8;
  localparam int DRAIN = 9;

  logic       clk, rst;
  logic       sel   [2];
  logic       mode  [2];
  logic       vin   [2];
  logic       grant [2];
  logic [7:0] din   [2];
  logic [7:0] dout  [2];
  logic       vout  [2];
  logic       rw    [2];
  logic       ready [2];
  logic       ack   [2];
  logic       sack  [2];
  logic       sreq  [2];

  int checks;
  int errors;

  logic [7:0]  mem_a [int];
  logic [7:0]  mem_b [int];
  logic [15:0] qa [$];
  logic [15:0] qb [$];

  split_target_mem_ctrl #(
    .ADDR_WIDTH(12), .ADDR_BYTES(2), .SPLIT_EN(1'b1), .SPLIT_LATENCY(LAT)
  ) u_split (
    .clk(clk), .rst(rst),
    .target_sel(sel[0]), .bus_mode(mode[0]),
    .target_data_in(din[0]), .target_data_in_valid(vin[0]),
    .split_grant(grant[0]),
    .target_data_out(dout[0]), .target_data_out_valid(vout[0]),
    .target_rw(rw[0]), .target_ready(ready[0]), .target_ack(ack[0]),
    .target_split_ack(sack[0]), .split_req(sreq[0])
  );

  split_target_mem_ctrl #(
    .ADDR_WIDTH(12), .ADDR_BYTES(2), .SPLIT_EN(1'b0), .SPLIT_LATENCY(LAT)
  ) u_nosplit (
    .clk(clk), .rst(rst),
    .target_sel(sel[1]), .bus_mode(mode[1]),
    .target_data_in(din[1]), .target_data_in_valid(vin[1]),
    .split_grant(grant[1]),
    .target_data_out(dout[1]), .target_data_out_valid(vout[1]),
    .target_rw(rw[1]), .target_ready(ready[1]), .target_ack(ack[1]),
    .target_split_ack(sack[1]), .split_req(sreq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_rd(input int d, input logic [15:0] a);
    int k;
    k = int'(a[11:0]);
    if (d == 0) return mem_a.exists(k) ? mem_a[k] : 8'hxx;
    return mem_b.exists(k) ? mem_b[k] : 8'hxx;
  endfunction

  task automatic model_wr(input int d, input logic [15:0] a, input logic [7:0] v);
    if (d == 0) mem_a[int'(a[11:0])] = v;
    else        mem_b[int'(a[11:0])] = v;
  endtask

  task automatic do_write(input int d, input logic [15:0] a, input logic [7:0] v);
    chk("wr_idle_ready", ready[d], 1);
    sel[d] = 1'b1; mode[d] = 1'b1;
    tick();
    vin[d] = 1'b1; din[d] = a[7:0];
    tick();
    din[d] = a[15:8];
    tick();
    din[d] = v;
    tick();
    vin[d] = 1'b0; sel[d] = 1'b0;
    chk("wr_ack", ack[d], 1);
    chk("wr_rw", rw[d], 1);
    tick();
    chk("wr_ack_single", ack[d], 0);
    chk("wr_back_ready", ready[d], 1);
    model_wr(d, a, v);
  endtask

  task automatic do_read(input int d, input logic [15:0] a, input int gdly, input bit spur);
    logic [7:0] exp;
    int n;
    exp = model_rd(d, a);
    sel[d] = 1'b1; mode[d] = 1'b0;
    tick();
    vin[d] = 1'b1; din[d] = a[7:0];
    tick();
    din[d] = a[15:8];
    tick();
    vin[d] = 1'b0; sel[d] = 1'b0;
    chk("rd_rw", rw[d], 0);
    if (d == 0) begin
      chk("rd_split_ack", sack[d], 1);
      chk("rd_no_valid_yet", vout[d], 0);
      n = 0;
      do begin
        grant[d] = spur; vin[d] = spur; din[d] = 8'($urandom);
        tick();
        n++;
      end while (!sreq[d] && n < 40);
      grant[d] = 1'b0; vin[d] = 1'b0;
      chk("split_latency", n, LAT);
      for (int i = 0; i < gdly; i++) tick();
      chk("split_req_held", sreq[d], 1);
      chk("split_ack_single", sack[d], 0);
      grant[d] = 1'b1;
      tick();
      grant[d] = 1'b0;
      chk("split_req_dropped", sreq[d], 0);
    end else begin
      chk("nosplit_no_sack", sack[d], 0);
      chk("nosplit_no_sreq", sreq[d], 0);
    end
    chk("rd_valid", vout[d], 1);
    chk("rd_data", dout[d], exp);
    n = 0;
    do begin
      vin[d] = spur; din[d] = 8'($urandom);
      tick();
      n++;
    end while (!ack[d] && n < 40);
    vin[d] = 1'b0;
    chk("drain_latency", n, DRAIN);
    chk("rd_data_hold", dout[d], exp);
    chk("rd_valid_single", vout[d], 0);
    tick();
    chk("rd_ack_single", ack[d], 0);
    chk("rd_back_ready", ready[d], 1);
  endtask

  initial begin
    int n;
    int d;
    logic [15:0] a;
    logic [7:0]  v;

    checks = 0; errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 1'b0; mode[i] = 1'b0; vin[i] = 1'b0; grant[i] = 1'b0; din[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", ready[i], 1);
      chk("rst_ack", ack[i], 0);
      chk("rst_valid", vout[i], 0);
      chk("rst_dout", dout[i], 0);
      chk("rst_rw", rw[i], 0);
      chk("rst_sreq", sreq[i], 0);
      chk("rst_sack", sack[i], 0);
    end
    rst = 1'b0;
    tick();

    // Write then split read of the same location.
    do_write(0, 16'h0234, 8'hA5);
    do_read(0, 16'h0234, 3, 1'b0);

    // Abort after the first address byte.
    sel[0] = 1'b1; mode[0] = 1'b1;
    tick();
    vin[0] = 1'b1; din[0] = 8'h34;
    tick();
    vin[0] = 1'b0; sel[0] = 1'b0;
    tick();
    chk("abort_addr_ready", ready[0], 1);
    chk("abort_addr_no_ack", ack[0], 0);

    // Abort in the data phase with a byte present: no RAM write.
    sel[0] = 1'b1; mode[0] = 1'b1;
    tick();
    vin[0] = 1'b1; din[0] = 8'h34;
    tick();
    din[0] = 8'h02;
    tick();
    sel[0] = 1'b0; din[0] = 8'hFF;
    tick();
    vin[0] = 1'b0;
    chk("abort_data_ready", ready[0], 1);
    chk("abort_data_no_ack", ack[0], 0);
    tick();
    chk("abort_data_no_ack2", ack[0], 0);
    do_write(0, 16'h0F17, 8'h3C);
    do_read(0, 16'h0234, 0, 1'b0);
    do_read(0, 16'h0F17, 1, 1'b0);

    // Spurious grant and stray bytes while idle.
    grant[0] = 1'b1; vin[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din[0] = 8'($urandom);
      tick();
      chk("spur_idle_ready", ready[0], 1);
      chk("spur_idle_sreq", sreq[0], 0);
      chk("spur_idle_valid", vout[0], 0);
    end
    grant[0] = 1'b0; vin[0] = 1'b0;

    // Upper address bits ignored; spurious grant in S_WAIT, stray bytes in S_DRAIN.
    do_read(0, 16'hF234, 2, 1'b1);

    // Reset while requesting the bus.
    sel[0] = 1'b1; mode[0] = 1'b0;
    tick();
    vin[0] = 1'b1; din[0] = 8'h34;
    tick();
    din[0] = 8'h02;
    tick();
    vin[0] = 1'b0; sel[0] = 1'b0;
    n = 0;
    while (!sreq[0] && n < 40) begin
      tick();
      n++;
    end
    chk("rstreq_latency", n, LAT);
    #2 rst = 1'b1;
    #1;
    chk("rstreq_sreq_drop", sreq[0], 0);
    chk("rstreq_ready", ready[0], 1);
    chk("rstreq_valid", vout[0], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("rstreq_idle", ready[0], 1);
    do_read(0, 16'h0234, 0, 1'b0);

    // Immediate-read target.
    do_write(1, 16'h0234, 8'h5A);
    do_read(1, 16'h0234, 0, 1'b1);
    qa.push_back(16'h0234); qa.push_back(16'h0F17);
    qb.push_back(16'h0234);

    // Random traffic against the byte-array model.
    for (int i = 0; i < 24; i++) begin
      d = i % 2;
      a = 16'($urandom);
      v = 8'($urandom);
      do_write(d, a, v);
      if (d == 0) begin
        qa.push_back(a);
        a = qa[$urandom_range(0, qa.size() - 1)];
      end else begin
        qb.push_back(a);
        a = qb[$urandom_range(0, qb.size() - 1)];
      end
      do_read(d, a, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
